cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Hardware commit-trace capture for the single-cycle CPU. Every cycle the CPU advances its PC, the block snapshots that instruction's PC, encoding, writeback data and write strobes into a small record FIFO. A host drains the FIFO as a stream of 32-bit words over a valid/ready port. It sits beside the CPU on its debug outputs, replacing waveform-only observation of those signals.

## Interface
- DEPTH, 16, record capacity; power of two, ≥2
- CNT_W, $clog2(DEPTH)+1, width of `count`
- clk  in  1  rising-edge clock, shared with the CPU
- reset  in  1  asynchronous, active-low; 0 clears all state
- enable  in  1  capture enable; sampled each edge
- clear  in  1  synchronous flush of FIFO, readout position and overflow flag
- PCWrite  in  1  CPU commit strobe: the current instruction retires this edge
- currPC  in  32  PC of the committing instruction
- instruction  in  32  encoding of the committing instruction
- dbData  in  32  register writeback data
- RegWrite  in  1  register-write strobe of the committing instruction
- MemWrite  in  1  memory-write strobe of the committing instruction
- out_valid  out  1  a trace word is presented
- out_data  out  32  trace word
- out_last  out  1  presented word is the final word of its record
- out_ready  in  1  host accepts the word when out_valid & out_ready
- count  out  CNT_W  stored records, including a partially read one
- overflow  out  1  sticky: at least one commit was dropped

## Operation
- Record = 4 words, sent in order:
  - w0 = currPC
  - w1 = instruction
  - w2 = dbData
  - w3 = {30'b0, MemWrite, RegWrite}
- Capture condition: edge with reset=1, clear=0, enable=1, PCWrite=1.
  - If count<DEPTH: write the record at wr_ptr; wr_ptr+1 mod DEPTH.
  - If count==DEPTH: drop the record and set overflow=1.
- Fullness is evaluated before the edge. A capture that coincides with the final (w3) read of a full FIFO is still dropped.
- Readout uses a 2-bit word index, idx.
  - out_valid = (count!=0).
  - out_data = word[idx] of the record at rd_ptr; forced to 0 when out_valid=0.
  - out_last = out_valid & (idx==3).
- Handshake:
  - Each out_valid & out_ready edge advances idx by one.
  - At idx==3 the handshake sets idx to 0 and advances rd_ptr by one mod DEPTH.
  - Word and record count are held while out_ready=0. out_valid never drops without a handshake, except on clear or reset.
- A simultaneous capture and record-retiring read leaves count unchanged. Pointers move independently and wrap modulo DEPTH.
- clear has priority over capture and readout in the same cycle: pointers, idx, count and overflow go to 0. Stored data is don't-care.
- enable=0 blocks capture only; readout continues.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, count=0, overflow=0, idx=0, both pointers=0.
- Reset asserted mid-readout abandons the partial record. There is no resume.
- Capture-to-visibility latency: a record captured at edge N gives out_valid=1 with w0 in the cycle after edge N.
- Throughput: one word per cycle with out_ready held high, so 4 cycles per record. Sustained CPU commits at one per cycle therefore overflow; this is expected and is flagged by overflow.
- count updates on the same edge as the capture or the retiring w3 handshake.
- The outputs are driven from registers plus an array read mux. There is no combinational path from out_ready to out_valid or out_data.

## Structure
- Package trace_pkg holds:
  - WORDS_PER_REC=4
  - the word-index typedef (2-bit)
  - flag bit positions in w3 (REGWRITE_BIT=0, MEMWRITE_BIT=1)
- Sub-module trace_fifo holds the 4×32-bit-wide, DEPTH-deep record storage, wr_ptr/rd_ptr, count, full/empty and the clear logic.
- The top level holds the capture qualifier, the overflow flag and the word-index readout sequencer.

## Test plan
- Reset, then one commit (PC=0x00000004, instr=0x02324020, dbData=0x5, RegWrite=1, MemWrite=0) with out_ready=1 -> words 0x4, 0x02324020, 0x5, 0x1 on consecutive cycles; out_last only on the fourth; count goes 1 then 0.
- 16 commits with out_ready=0, then a 17th -> count=16, overflow=1. Draining yields records 1–16 in order; the 17th is absent.
- out_ready toggling every cycle mid-record -> out_data stable while stalled, no word skipped or duplicated.
- Full FIFO: capture on the same edge as the w3 handshake -> capture dropped, overflow=1, count=15.
- clear asserted with PCWrite=1 and the handshake active -> count=0, overflow=0, out_valid=0 next cycle.
- reset pulsed low mid-record (after w1) -> all outputs 0 immediately. A subsequent commit reads out starting at w0.

Source files
------------

// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the CPU commit-trace buffer.
//   WORDS_PER_REC  : trace words emitted per committed instruction
//   word_idx_t     : index of a word within a record (0..3)
//   REGWRITE_BIT / MEMWRITE_BIT : flag positions inside the fourth word
//   pack_record()  : builds the 128-bit stored record from commit signals
//   record_word()  : selects one 32-bit word out of a stored record
// ---------------------------------------------------------------------------
package trace_pkg;

  localparam int WORDS_PER_REC = 4;
  localparam int WORD_W        = 32;
  localparam int REC_W         = WORDS_PER_REC * WORD_W;

  typedef logic [1:0] word_idx_t;

  localparam word_idx_t LAST_IDX = 2'd3;

  localparam int REGWRITE_BIT = 0;
  localparam int MEMWRITE_BIT = 1;

  // Word 0 occupies the least-significant 32 bits so that the word index
  // maps directly onto a slice position.
  function automatic logic [REC_W-1:0] pack_record(
    input logic [WORD_W-1:0] pc,
    input logic [WORD_W-1:0] instr,
    input logic [WORD_W-1:0] wb_data,
    input logic              reg_write,
    input logic              mem_write
  );
    logic [WORD_W-1:0] flags;
    flags               = '0;
    flags[REGWRITE_BIT] = reg_write;
    flags[MEMWRITE_BIT] = mem_write;
    return {flags, wb_data, instr, pc};
  endfunction

  function automatic logic [WORD_W-1:0] record_word(
    input logic [REC_W-1:0] rec,
    input word_idx_t        idx
  );
    logic [WORD_W-1:0] word;
    case (idx)
      2'd0:    word = rec[0*WORD_W +: WORD_W];
      2'd1:    word = rec[1*WORD_W +: WORD_W];
      2'd2:    word = rec[2*WORD_W +: WORD_W];
      default: word = rec[3*WORD_W +: WORD_W];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// cpu_trace_buffer_if
// Word stream from the trace buffer to the host.
//   out_valid : a trace word is presented
//   out_data  : the trace word
//   out_last  : presented word closes its record
//   out_ready : host accepts the word on out_valid & out_ready
// master = trace buffer side, slave = host side.
// ---------------------------------------------------------------------------
interface cpu_trace_buffer_if;
  import trace_pkg::*;

  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// DEPTH-deep store of 128-bit trace records with occupancy tracking.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : synchronous flush, wins over push and pop
//   push       : write wr_rec (ignored when full)
//   pop        : retire the record at the read pointer (ignored when empty)
//   wr_rec     : record to store
//   rd_rec     : record at the read pointer (combinational array read)
//   count      : stored records, including one being read out
//   full/empty : occupancy flags derived from count
// ---------------------------------------------------------------------------
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [REC_W-1:0] wr_rec,
  output logic [REC_W-1:0] rd_rec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Fullness is taken from the pre-edge count, so a push that lands on the
  // same edge as the pop of a full FIFO is still refused.
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  assign rd_rec = mem[rd_ptr];

  // Storage needs no reset: nothing is read until count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_rec;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// ---------------------------------------------------------------------------
// cpu_trace_buffer
// Snapshots every CPU commit into a record FIFO and streams the records to a
// host as four 32-bit words each (PC, instruction, writeback data, flags).
//   clk, reset  : clock shared with the CPU, asynchronous active-low reset
//   enable      : capture enable (readout is unaffected)
//   clear       : synchronous flush of FIFO, word index and overflow flag
//   PCWrite     : commit strobe from the CPU
//   currPC, instruction, dbData, RegWrite, MemWrite : commit snapshot
//   trace       : word stream to the host (valid/ready)
//   count       : stored records, including a partially read one
//   overflow    : sticky, a commit arrived while the FIFO was full
// ---------------------------------------------------------------------------
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       PCWrite,
  input  logic [31:0]                currPC,
  input  logic [31:0]                instruction,
  input  logic [31:0]                dbData,
  input  logic                       RegWrite,
  input  logic                       MemWrite,
  cpu_trace_buffer_if.master         trace,
  output logic [CNT_W-1:0]           count,
  output logic                       overflow
);

  logic             capture;
  logic             handshake;
  logic             retire;
  logic             full;
  logic             empty;
  logic [REC_W-1:0] wr_rec;
  logic [REC_W-1:0] rd_rec;
  word_idx_t        idx;

  assign capture   = enable && PCWrite && !clear;
  assign handshake = trace.out_valid && trace.out_ready;
  assign retire    = handshake && (idx == LAST_IDX);
  assign wr_rec    = pack_record(currPC, instruction, dbData, RegWrite, MemWrite);

  trace_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .push   (capture),
    .pop    (retire),
    .wr_rec (wr_rec),
    .rd_rec (rd_rec),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // A commit seen while full is lost; remember that until clear or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (capture && full) begin
      overflow <= 1'b1;
    end
  end

  // Word index within the record at the read pointer; wraps 3 -> 0 on the
  // same handshake that retires the record in the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (handshake) begin
      idx <= idx + 2'd1;
    end
  end

  // Outputs depend only on registered state and the array read, never on
  // out_ready.
  always_comb begin
    trace.out_valid = !empty;
    trace.out_data  = '0;
    trace.out_last  = 1'b0;
    if (!empty) begin
      trace.out_data = record_word(rd_rec, idx);
      trace.out_last = (idx == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_cpu_trace_buffer
// Self-checking bench for cpu_trace_buffer. The reference model is a flat
// queue of pending trace words; the driver pushes the word it expects the
// host to accept into a scoreboard queue, and a negedge monitor pops and
// compares whenever the DUT completes a handshake.
// ---------------------------------------------------------------------------
module tb_cpu_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } word_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             clear;
  logic             PCWrite;
  logic [31:0]      currPC;
  logic [31:0]      instruction;
  logic [31:0]      dbData;
  logic             RegWrite;
  logic             MemWrite;
  logic [CNT_W-1:0] count;
  logic             overflow;

  cpu_trace_buffer_if trace_if ();

  cpu_trace_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .PCWrite     (PCWrite),
    .currPC      (currPC),
    .instruction (instruction),
    .dbData      (dbData),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .trace       (trace_if.master),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  word_t model_words[$];
  word_t sb_q[$];
  logic  model_ovf;
  int    tests;
  int    failures;

  // Records still held = pending words rounded up to whole records.
  function automatic int modelCount();
    return (model_words.size() + 3) / 4;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("count", 32'(count), 32'(modelCount()));
    checkVal("overflow", 32'(overflow), 32'(model_ovf));
    checkVal("out_valid", 32'(trace_if.out_valid), 32'(model_words.size() != 0));
    if (model_words.size() == 0) begin
      checkVal("idle_data", trace_if.out_data, 32'h0);
      checkVal("idle_last", 32'(trace_if.out_last), 32'h0);
    end
  endtask

  // Called at posedge+1: drives inputs for the next edge, advances the model
  // by that edge, then checks the state after it.
  task automatic applyStimulus(input logic en, input logic pcw, input logic [31:0] pc,
                               input logic [31:0] ins, input logic [31:0] db,
                               input logic rw, input logic mw, input logic rdy,
                               input logic clr);
    bit was_full;
    enable      = en;
    PCWrite     = pcw;
    currPC      = pc;
    instruction = ins;
    dbData      = db;
    RegWrite    = rw;
    MemWrite    = mw;
    trace_if.out_ready = rdy;
    clear       = clr;
    if (clr) begin
      model_words.delete();
      model_ovf = 1'b0;
    end else begin
      was_full = (modelCount() == DEPTH);
      if (model_words.size() != 0 && rdy) begin
        sb_q.push_back(model_words.pop_front());
      end
      if (en && pcw) begin
        if (was_full) begin
          model_ovf = 1'b1;
        end else begin
          model_words.push_back(word_t'({1'b0, pc}));
          model_words.push_back(word_t'({1'b0, ins}));
          model_words.push_back(word_t'({1'b0, db}));
          model_words.push_back(word_t'({1'b1, 30'b0, mw, rw}));
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic commit(input logic rdy);
    applyStimulus(1'b1, 1'b1, $urandom, $urandom, $urandom,
                  1'($urandom), 1'($urandom), rdy, 1'b0);
  endtask

  task automatic doClear();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: every accepted word must be the next one the model expects, and
  // a stalled word must not change until accepted.
  logic        stalled = 1'b0;
  logic [31:0] stall_data = 32'h0;

  always @(negedge clk) begin
    word_t w;
    if (reset !== 1'b1 || clear) begin
      stalled = 1'b0;
    end else if (trace_if.out_valid) begin
      if (stalled) begin
        checkVal("stall_hold", trace_if.out_data, stall_data);
      end
      if (trace_if.out_ready) begin
        stalled = 1'b0;
        checkVal("word_expected", 32'(sb_q.size() != 0), 32'h1);
        if (sb_q.size() != 0) begin
          w = sb_q.pop_front();
          checkVal("word_data", trace_if.out_data, w.data);
          checkVal("word_last", 32'(trace_if.out_last), 32'(w.last));
        end
      end else begin
        stalled    = 1'b1;
        stall_data = trace_if.out_data;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    tests     = 0;
    failures  = 0;
    model_ovf = 1'b0;
    reset     = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    PCWrite   = 1'b0;
    currPC    = '0;
    instruction = '0;
    dbData    = '0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    trace_if.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    reset = 1'b1;

    // Single directed commit, drained at full rate
    applyStimulus(1'b1, 1'b1, 32'h0000_0004, 32'h0232_4020, 32'h0000_0005,
                  1'b1, 1'b0, 1'b1, 1'b0);
    checkVal("first_count", 32'(count), 32'd1);
    idle(4, 1'b1);
    checkVal("first_drained", 32'(count), 32'd0);

    // Fill to capacity, one more commit overflows; drain all 16
    for (int i = 0; i < DEPTH + 1; i++) begin
      commit(1'b0);
    end
    checkVal("full_count", 32'(count), 32'd16);
    checkVal("full_overflow", 32'(overflow), 32'd1);
    idle(DEPTH * 4, 1'b1);
    checkVal("full_drained", 32'(count), 32'd0);

    // Stalling host: ready toggles every cycle mid-record
    doClear();
    commit(1'b0);
    commit(1'b0);
    for (int i = 0; i < 20; i++) begin
      idle(1, 1'(i % 2));
    end
    idle(12, 1'b1);

    // Capture on the same edge as the retiring read of a full FIFO
    doClear();
    for (int i = 0; i < DEPTH; i++) begin
      commit(1'b0);
    end
    idle(3, 1'b1);
    commit(1'b1);
    checkVal("retire_full_count", 32'(count), 32'd15);
    checkVal("retire_full_overflow", 32'(overflow), 32'd1);
    idle(2, 1'b1);

    // clear beats capture and readout in the same cycle
    applyStimulus(1'b1, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkVal("clear_count", 32'(count), 32'd0);
    checkVal("clear_overflow", 32'(overflow), 32'd0);
    checkVal("clear_valid", 32'(trace_if.out_valid), 32'd0);

    // Reset mid-record abandons it; next record starts at w0
    commit(1'b1);
    idle(2, 1'b1);
    reset = 1'b0;
    #1;
    checkVal("rst_valid", 32'(trace_if.out_valid), 32'd0);
    checkVal("rst_data", trace_if.out_data, 32'd0);
    checkVal("rst_last", 32'(trace_if.out_last), 32'd0);
    checkVal("rst_count", 32'(count), 32'd0);
    checkVal("rst_overflow", 32'(overflow), 32'd0);
    model_words.delete();
    model_ovf = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    commit(1'b1);
    idle(4, 1'b1);
    checkVal("post_rst_drained", 32'(count), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom % 8 != 0), 1'($urandom % 3 == 0), $urandom, $urandom,
                    $urandom, 1'($urandom), 1'($urandom), 1'($urandom % 4 != 0),
                    1'($urandom % 64 == 0));
    end
    idle(DEPTH * 4 + 4, 1'b1);
    checkVal("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
